// File: rtl/sub_pkg.sv
// Shared definitions for the digit-serial subtractor.
//   state_t  : controller states (IDLE / RUN / DONE)
//   NDIG     : digits per operation at the default width/digit size
//   CNT_W    : digit counter width at the default sizes
//   ovf_calc : two's-complement overflow of a - b from the three sign bits
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_DIGIT = 4;
  localparam int unsigned NDIG      = DEF_WIDTH / DEF_DIGIT;
  localparam int unsigned CNT_W     = $clog2(NDIG) + 1;

  // Overflow happens only when the operand signs differ and the result sign
  // differs from the minuend sign.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb,
                                    input logic d_msb);
    return (a_msb ^ b_msb) & (a_msb ^ d_msb);
  endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit subtractor slice: d = a - b - bin.
// Built from a chain of 1-bit full subtractors, the mirror image of the
// adder's full-adder slice.
//   a, b : digit operands
//   bin  : borrow in from the less significant digit
//   d    : result digit
//   bout : borrow out to the more significant digit
module sub_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] br;

  always_comb begin
    br    = '0;
    d     = '0;
    br[0] = bin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      d[i]      = a[i] ^ b[i] ^ br[i];
      // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
      br[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end
    bout = br[DIGIT];
  end

endmodule

// File: rtl/sub64_serial.sv
// Digit-serial subtractor: diff = op1 - op2, one DIGIT-bit slice per cycle,
// least significant digit first, borrow held in a register.
//   clock, reset        : single clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (accepted only in IDLE)
//   op1, op2            : minuend / subtrahend
//   out_valid/out_ready : result handshake (result presented in DONE)
//   diff                : op1 - op2 modulo 2^WIDTH
//   bout                : unsigned borrow out (op1 < op2)
//   ovf                 : signed two's-complement overflow
module sub64_serial
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIGIT = DEF_DIGIT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned N_DIG = WIDTH / DIGIT;
  localparam int unsigned C_W   = $clog2(N_DIG) + 1;

  state_t           state, state_n;
  logic [C_W-1:0]   cnt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             a_msb_q, b_msb_q;
  logic             borrow_q;
  logic [WIDTH-1:0] diff_q, diff_n;
  logic             bout_q, ovf_q;
  logic [DIGIT-1:0] dig_d;
  logic             dig_b;
  logic             last;

  assign last = (cnt == C_W'(N_DIG - 1));

  // Operand registers shift right each RUN cycle so the active digit always
  // sits in the low slice; the sign bits are captured separately for ovf.
  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .bin  (borrow_q),
    .d    (dig_d),
    .bout (dig_b)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)  state_n = RUN;
      RUN:     if (last)      state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Drop the freshly computed digit into its final position; digits not yet
  // reached stay at the zero written on accept.
  always_comb begin
    diff_n = diff_q;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      if (cnt == C_W'(i)) diff_n[i*DIGIT +: DIGIT] = dig_d;
    end
  end

  // Datapath
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= op1;
            b_q      <= op2;
            a_msb_q  <= op1[WIDTH-1];
            b_msb_q  <= op2[WIDTH-1];
            borrow_q <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
          end
        end
        RUN: begin
          a_q      <= a_q >> DIGIT;
          b_q      <= b_q >> DIGIT;
          borrow_q <= dig_b;
          cnt      <= cnt + C_W'(1);
          diff_q   <= diff_n;
          if (last) begin
            bout_q <= dig_b;
            ovf_q  <= ovf_calc(a_msb_q, b_msb_q, dig_d[DIGIT-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_sub64_serial.sv
module tb_sub64_serial;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] op1;
  logic [63:0] op2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        bout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  sub64_serial #(.WIDTH(64), .DIGIT(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on wider signed/unsigned values.
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] d, output logic bo, output logic ov);
    logic signed [65:0] r;
    d  = a - b;
    bo = (a < b);
    r  = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
    // Result fits a 64-bit signed value iff bits 65..63 all agree.
    ov = !((r[65:63] == 3'b000) || (r[65:63] == 3'b111));
  endfunction

  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input int stall, input bit inject, input int rst_at);
    logic [63:0] ed, mask;
    logic        eb, eo;
    int          k, t;
    model(a, b, ed, eb, eo);
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    check("in_ready_idle", 64'(in_ready), 64'd1);
    op1 = a; op2 = b; in_valid = 1'b1; out_ready = (stall == 0);
    @(negedge clock);
    in_valid = 1'b0;
    op1 = {$urandom, $urandom};
    op2 = {$urandom, $urandom};
    k = 0;
    while (!out_valid && k < 40) begin
      check("in_ready_busy", 64'(in_ready), 64'd0);
      if (k < 16) begin
        mask = (64'h1 << (4 * k)) - 64'h1;
        check("partial_diff", diff, ed & mask);
      end
      if (inject && k == 3) in_valid = 1'b1;
      if (k == rst_at) begin
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_diff", diff, 64'd0);
        check("rst_bout", 64'(bout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        return;
      end
      @(negedge clock);
      k++;
    end
    check("latency", 64'(k), 64'd16);
    for (int i = 0; i < stall; i++) begin
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_diff", diff, ed);
      check("stall_bout", 64'(bout), 64'(eb));
      check("stall_ovf", 64'(ovf), 64'(eo));
      @(negedge clock);
    end
    out_ready = 1'b1;
    check("out_valid", 64'(out_valid), 64'd1);
    check("diff", diff, ed);
    check("bout", 64'(bout), 64'(eb));
    check("ovf", 64'(ovf), 64'(eo));
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("post_out_valid", 64'(out_valid), 64'd0);
    check("post_in_ready", 64'(in_ready), 64'd1);
    check("post_diff_held", diff, ed);
    check("post_bout_held", 64'(bout), 64'(eb));
  endtask

  initial begin
    logic [63:0] ra, rb;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op1 = '0; op2 = '0;
    repeat (3) @(negedge clock);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_diff", diff, 64'd0);
    check("reset_bout", 64'(bout), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    run_op(64'h5, 64'h3, 0, 1'b0, -1);
    run_op(64'h0, 64'h1, 0, 1'b0, -1);
    run_op(64'h0000_0001_0000_0000, 64'h1, 0, 1'b0, -1);
    run_op(64'h8000_0000_0000_0000, 64'h1, 0, 1'b0, -1);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0, -1);
    run_op(64'h10, 64'h20, 5, 1'b1, -1);
    run_op({$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0, 8);
    run_op(64'h64, 64'h64, 0, 1'b0, -1);

    for (int n = 0; n < 24; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (n % 4 == 1) rb = ra + 64'($urandom_range(0, 2)) - 64'd1;
      if (n % 4 == 2) ra[63] = ~rb[63];
      run_op(ra, rb, int'($urandom_range(0, 3)), n[0], -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
